spectro_frame_rx: RTL and testbench

Receiving end of the spectrogram serial readout link. Deserializes one acoustic-event frame: a 30-bit RTC timestamp followed by bank memory words. Recovers timestamp, words, word address and bank boundaries. Sits on the host/FPGA side, driven by the link signals the readout FSM produces (data bit, bit qualifier, frame envelope, RTC/memory selection).

---
 rtl/spectro_link_pkg.sv | 18 +
 rtl/spectro_frame_rx_if.sv | 12 +
 rtl/spectro_shift_in.sv | 44 ++++
 rtl/spectro_frame_rx.sv | 184 ++++++++++++++++++
 tb/tb_spectro_frame_rx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spectro_link_pkg.sv
// Constants and state encoding shared by both ends of the spectrogram readout link.
package spectro_link_pkg;

   localparam int RTC_W      = 30;
   localparam int WORD_W     = 8;
   localparam int BANK_WORDS = 200;

   localparam logic RTC_SEL = 1'b0;
   localparam logic MEM_SEL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RTC   = 2'd1,
      ST_DATA  = 2'd2,
      ST_CLOSE = 2'd3
   } rx_state_e;

endpackage

// File: rtl/spectro_frame_rx_if.sv
// Serial readout link as seen between the readout FSM (master) and the receiver (slave).
interface spectro_frame_rx_if;

   logic rx_en;
   logic rx_bit_valid;
   logic rx_data;
   logic rx_sel;

   modport master (output rx_en, output rx_bit_valid, output rx_data, output rx_sel);
   modport slave  (input  rx_en, input  rx_bit_valid, input  rx_data, input  rx_sel);

endinterface

// File: rtl/spectro_shift_in.sv
// MSB-first serial-in shift register; done flags the cycle the W-th bit is being accepted.
module spectro_shift_in #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         shift_en,
   input  logic         bit_in,
   output logic [W-1:0] data_nxt,
   output logic         partial,
   output logic         done
);

   logic [W-1:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      data_nxt = {data_q[W-2:0], bit_in};
      done     = shift_en && (cnt_q == CW'(W - 1));
      partial  = (cnt_q != '0);
      data_d   = data_q;
      cnt_d    = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (shift_en) begin
         data_d = data_nxt;
         cnt_d  = done ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/spectro_frame_rx.sv
// Frame receiver: timestamp then bank words, with address/bank recovery and frame-level errors.
module spectro_frame_rx #(
   parameter int RTC_W      = spectro_link_pkg::RTC_W,
   parameter int WORD_W     = spectro_link_pkg::WORD_W,
   parameter int BANK_WORDS = spectro_link_pkg::BANK_WORDS,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   spectro_frame_rx_if.slave  link,
   output logic [RTC_W-1:0]   rtc_value,
   output logic               rtc_valid,
   output logic [WORD_W-1:0]  word_data,
   output logic [7:0]         word_addr,
   output logic               word_bank,
   output logic               word_valid,
   output logic               bank_done,
   output logic               frame_done,
   output logic [CNT_W-1:0]   word_count,
   output logic               err_rtc_short,
   output logic               err_partial,
   output logic               busy
);

   import spectro_link_pkg::*;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   rx_state_e         state_q, state_d;
   logic [RTC_W-1:0]  rtc_value_q, rtc_value_d;
   logic [WORD_W-1:0] word_data_q, word_data_d;
   logic [7:0]        word_addr_q, word_addr_d, ptr_q, ptr_d;
   logic [CNT_W-1:0]  word_count_q, word_count_d;
   logic word_bank_q, word_bank_d, bank_q, bank_d;
   logic rtc_valid_q, rtc_valid_d, word_valid_q, word_valid_d;
   logic bank_done_q, bank_done_d, frame_done_q, frame_done_d;
   logic err_rtc_short_q, err_rtc_short_d, err_partial_q, err_partial_d;
   logic busy_q, busy_d;

   logic acc_rtc, acc_mem;
   logic rtc_shift, rtc_clr, rtc_done, rtc_part;
   logic wrd_shift, wrd_clr, wrd_done, wrd_part;
   logic [RTC_W-1:0]  rtc_nxt;
   logic [WORD_W-1:0] wrd_nxt;

   spectro_shift_in #(.W(RTC_W)) u_rtc_shift (
      .clk(clk), .reset(reset), .clr(rtc_clr), .shift_en(rtc_shift), .bit_in(link.rx_data),
      .data_nxt(rtc_nxt), .partial(rtc_part), .done(rtc_done)
   );

   spectro_shift_in #(.W(WORD_W)) u_word_shift (
      .clk(clk), .reset(reset), .clr(wrd_clr), .shift_en(wrd_shift), .bit_in(link.rx_data),
      .data_nxt(wrd_nxt), .partial(wrd_part), .done(wrd_done)
   );

   always_comb begin
      acc_rtc         = link.rx_en && link.rx_bit_valid && (link.rx_sel == RTC_SEL);
      acc_mem         = link.rx_en && link.rx_bit_valid && (link.rx_sel == MEM_SEL);
      state_d         = state_q;
      rtc_value_d     = rtc_value_q;
      word_data_d     = word_data_q;
      word_addr_d     = word_addr_q;
      word_bank_d     = word_bank_q;
      word_count_d    = word_count_q;
      ptr_d           = ptr_q;
      bank_d          = bank_q;
      rtc_valid_d     = 1'b0;
      word_valid_d    = 1'b0;
      bank_done_d     = 1'b0;
      frame_done_d    = 1'b0;
      err_rtc_short_d = 1'b0;
      err_partial_d   = 1'b0;
      rtc_shift       = 1'b0;
      rtc_clr         = 1'b0;
      wrd_shift       = 1'b0;
      wrd_clr         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (acc_rtc) begin
               rtc_shift    = 1'b1;
               word_count_d = '0;
               state_d      = ST_RTC;
            end
         end
         ST_RTC: begin
            // A memory bit or a dropped envelope kills the timestamp; the offending bit is not kept.
            if (!link.rx_en || acc_mem) begin
               err_rtc_short_d = rtc_part;
               rtc_clr         = 1'b1;
               state_d         = ST_IDLE;
            end else if (acc_rtc) begin
               rtc_shift = 1'b1;
               if (rtc_done) begin
                  rtc_value_d = rtc_nxt;
                  rtc_valid_d = 1'b1;
                  ptr_d       = '0;
                  wrd_clr     = 1'b1;
                  state_d     = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (!link.rx_en) begin
               state_d = ST_CLOSE;
            end else if (acc_mem) begin
               wrd_shift = 1'b1;
               if (wrd_done) begin
                  word_valid_d = 1'b1;
                  word_data_d  = wrd_nxt;
                  word_addr_d  = ptr_q;
                  word_bank_d  = bank_q;
                  word_count_d = sat_inc(word_count_q);
                  if (ptr_q == 8'(BANK_WORDS - 1)) begin
                     bank_done_d = 1'b1;
                     ptr_d       = '0;
                     bank_d      = ~bank_q;
                  end else begin
                     ptr_d = ptr_q + 8'd1;
                  end
               end
            end
         end
         default: begin
            frame_done_d  = 1'b1;
            err_partial_d = wrd_part;
            wrd_clr       = 1'b1;
            state_d       = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         rtc_value_q     <= '0;
         word_data_q     <= '0;
         word_addr_q     <= '0;
         word_bank_q     <= 1'b0;
         word_count_q    <= '0;
         ptr_q           <= '0;
         bank_q          <= 1'b0;
         rtc_valid_q     <= 1'b0;
         word_valid_q    <= 1'b0;
         bank_done_q     <= 1'b0;
         frame_done_q    <= 1'b0;
         err_rtc_short_q <= 1'b0;
         err_partial_q   <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         rtc_value_q     <= rtc_value_d;
         word_data_q     <= word_data_d;
         word_addr_q     <= word_addr_d;
         word_bank_q     <= word_bank_d;
         word_count_q    <= word_count_d;
         ptr_q           <= ptr_d;
         bank_q          <= bank_d;
         rtc_valid_q     <= rtc_valid_d;
         word_valid_q    <= word_valid_d;
         bank_done_q     <= bank_done_d;
         frame_done_q    <= frame_done_d;
         err_rtc_short_q <= err_rtc_short_d;
         err_partial_q   <= err_partial_d;
         busy_q          <= busy_d;
      end
   end

   assign rtc_value     = rtc_value_q;
   assign rtc_valid     = rtc_valid_q;
   assign word_data     = word_data_q;
   assign word_addr     = word_addr_q;
   assign word_bank     = word_bank_q;
   assign word_valid    = word_valid_q;
   assign bank_done     = bank_done_q;
   assign frame_done    = frame_done_q;
   assign word_count    = word_count_q;
   assign err_rtc_short = err_rtc_short_q;
   assign err_partial   = err_partial_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_spectro_frame_rx.sv
// Randomized frame-level bench for spectro_frame_rx with a queue-based scoreboard.
module tb_spectro_frame_rx;
   import spectro_link_pkg::*;

   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spectro_frame_rx_if link ();

   logic [RTC_W-1:0]  rtc_value;
   logic [WORD_W-1:0] word_data;
   logic [7:0]        word_addr;
   logic [CNT_W-1:0]  word_count;
   logic rtc_valid, word_bank, word_valid, bank_done, frame_done;
   logic err_rtc_short, err_partial, busy;

   spectro_frame_rx #(.CNT_W(CNT_W)) u_dut (
      .clk(clk), .reset(reset), .link(link),
      .rtc_value(rtc_value), .rtc_valid(rtc_valid),
      .word_data(word_data), .word_addr(word_addr), .word_bank(word_bank),
      .word_valid(word_valid), .bank_done(bank_done), .frame_done(frame_done),
      .word_count(word_count), .err_rtc_short(err_rtc_short),
      .err_partial(err_partial), .busy(busy)
   );

   typedef struct { logic [WORD_W-1:0] data; logic [7:0] addr; logic bank; logic bd; } word_exp_t;
   typedef struct { logic [CNT_W-1:0] cnt; logic part; } frame_exp_t;

   logic [RTC_W-1:0] rtc_q[$];
   logic [RTC_W-1:0] short_q[$];
   word_exp_t        word_q[$];
   frame_exp_t       frame_q[$];
   logic [WORD_W-1:0] src[$];

   int n_vec = 0;
   int n_fail = 0;

   // Reference model of the link: bank pointer, bank parity and last good timestamp.
   int               m_ptr = 0;
   logic             m_bank = 1'b0;
   logic [RTC_W-1:0] m_rtc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   word_exp_t  mon_w;
   frame_exp_t mon_f;
   always @(negedge clk) begin
      if (!reset) begin
         if (rtc_valid) begin
            if (rtc_q.size() == 0) check("rtc_valid_unexpected", 32'(rtc_valid), 32'(0));
            else check("rtc_value", 32'(rtc_value), 32'(rtc_q.pop_front()));
         end
         if (word_valid) begin
            if (word_q.size() == 0) check("word_valid_unexpected", 32'(word_valid), 32'(0));
            else begin
               mon_w = word_q.pop_front();
               check("word_data", 32'(word_data), 32'(mon_w.data));
               check("word_addr", 32'(word_addr), 32'(mon_w.addr));
               check("word_bank", 32'(word_bank), 32'(mon_w.bank));
               check("bank_done", 32'(bank_done), 32'(mon_w.bd));
            end
         end else if (bank_done) check("bank_done_alone", 32'(bank_done), 32'(0));
         if (frame_done) begin
            if (frame_q.size() == 0) check("frame_done_unexpected", 32'(frame_done), 32'(0));
            else begin
               mon_f = frame_q.pop_front();
               check("word_count", 32'(word_count), 32'(mon_f.cnt));
               check("err_partial", 32'(err_partial), 32'(mon_f.part));
            end
         end else if (err_partial) check("err_partial_alone", 32'(err_partial), 32'(0));
         if (err_rtc_short) begin
            if (short_q.size() == 0) check("err_rtc_short_unexpected", 32'(err_rtc_short), 32'(0));
            else check("rtc_value_held", 32'(rtc_value), 32'(short_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic v, input logic d, input logic s);
      link.rx_en = en; link.rx_bit_valid = v; link.rx_data = d; link.rx_sel = s;
      tick();
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom), 1'($urandom));
   endtask

   task automatic maybe_gap(input bit rg);
      if (rg && $urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
   endtask

   task automatic send_rtc(input logic [RTC_W-1:0] v, input int nbits, input bit rg);
      for (int i = RTC_W - 1; i >= RTC_W - nbits; i--) begin
         drive(1'b1, 1'b1, v[i], RTC_SEL);
         if (i != RTC_W - nbits) maybe_gap(rg);
      end
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w, input int nbits, input bit rg, input bit junk);
      for (int i = WORD_W - 1; i >= WORD_W - nbits; i--) begin
         if (junk && $urandom_range(0, 7) == 0) drive(1'b1, 1'b1, 1'($urandom), RTC_SEL);
         drive(1'b1, 1'b1, w[i], MEM_SEL);
         if (i != WORD_W - nbits) maybe_gap(rg);
      end
   endtask

   task automatic expect_word(input logic [WORD_W-1:0] w);
      word_exp_t e;
      e.data = w;
      e.addr = 8'(m_ptr);
      e.bank = m_bank;
      e.bd   = (m_ptr == BANK_WORDS - 1);
      word_q.push_back(e);
      if (m_ptr == BANK_WORDS - 1) begin
         m_ptr  = 0;
         m_bank = ~m_bank;
      end else m_ptr++;
   endtask

   // Full frame: timestamp, every word queued in src, optional trailing partial word, envelope drop.
   task automatic run_frame(input logic [RTC_W-1:0] rtc, input int partial, input bit rg,
                            input bit junk, input bit coinc, input bit bank_gap, input bit lat);
      int cnt;
      logic [WORD_W-1:0] w;
      bit bd;
      frame_exp_t f;
      cnt = 0;
      if (junk) drive(1'b1, 1'b1, 1'($urandom), MEM_SEL);
      m_rtc = rtc;
      rtc_q.push_back(rtc);
      send_rtc(rtc, RTC_W, rg);
      if (lat) check("rtc_valid_latency", 32'(rtc_valid), 32'(1));
      maybe_gap(rg);
      m_ptr = 0;
      while (src.size() > 0) begin
         w  = src.pop_front();
         bd = (m_ptr == BANK_WORDS - 1);
         expect_word(w);
         if (cnt < (1 << CNT_W) - 1) cnt++;
         send_word(w, WORD_W, rg, junk);
         if (lat) check("word_valid_latency", 32'(word_valid), 32'(1));
         if (bank_gap && bd) gap(20);
         else maybe_gap(rg);
      end
      if (partial > 0) send_word(WORD_W'($urandom), partial, rg, junk);
      f.cnt  = CNT_W'(cnt);
      f.part = (partial != 0);
      frame_q.push_back(f);
      drive(1'b0, coinc, 1'($urandom), MEM_SEL);
      if (lat) check("frame_done_early", 32'(frame_done), 32'(0));
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (lat) check("frame_done_latency", 32'(frame_done), 32'(1));
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_abort(input int nbits, input bit by_sel, input bit rg);
      short_q.push_back(m_rtc);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      send_rtc(RTC_W'($urandom), nbits, rg);
      if (by_sel) begin
         drive(1'b1, 1'b1, 1'($urandom), MEM_SEL);
         send_word(WORD_W'($urandom), WORD_W, rg, 1'b0);
         send_word(WORD_W'($urandom), WORD_W, rg, 1'b0);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rtc_value"}, 32'(rtc_value), 32'(0));
      check({tag, "_word_data"}, 32'(word_data), 32'(0));
      check({tag, "_word_addr"}, 32'(word_addr), 32'(0));
      check({tag, "_word_count"}, 32'(word_count), 32'(0));
      check({tag, "_flags"},
            32'({rtc_valid, word_bank, word_valid, bank_done, frame_done, err_rtc_short, err_partial, busy}),
            32'(0));
   endtask

   initial begin
      link.rx_en = 1'b0; link.rx_bit_valid = 1'b0; link.rx_data = 1'b0; link.rx_sel = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Basic frame with known words and exact latency checks.
      src = '{8'hA5, 8'h3C, 8'hFF};
      run_frame(30'h2AAAAAAA, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Two bank wraps with a long idle gap after the first bank.
      for (int i = 0; i < 450; i++) src.push_back(WORD_W'(i % 256));
      run_frame(RTC_W'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Timestamp aborted by a memory bit after 17 bits, then by the envelope after 9.
      run_abort(17, 1'b1, 1'b0);
      run_abort(9, 1'b0, 1'b0);

      // Envelope drops 5 bits into the 4th word.
      src = '{8'h11, 8'h22, 8'h33};
      run_frame(RTC_W'($urandom), 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Last bit coincident with the envelope falling is lost.
      src = '{8'h44, 8'h55, 8'h66};
      run_frame(RTC_W'($urandom), 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Last bit one cycle before the envelope falls completes the word.
      src = '{8'h77, 8'h88, 8'h99};
      run_frame(RTC_W'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized frames with gaps, stray RTC bits in DATA and occasional aborts.
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(0, 4) == 0) begin
            run_abort(int'($urandom_range(1, RTC_W - 1)), 1'($urandom), 1'b1);
         end else begin
            for (int i = 0; i < int'($urandom_range(0, 25)); i++) src.push_back(WORD_W'($urandom));
            run_frame(RTC_W'($urandom), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, WORD_W - 1)),
                      1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
         end
      end

      // Reset in the middle of a frame, partway through word 51.
      m_rtc = RTC_W'($urandom);
      rtc_q.push_back(m_rtc);
      send_rtc(m_rtc, RTC_W, 1'b0);
      m_ptr = 0;
      for (int i = 0; i < 50; i++) begin
         src.push_back(WORD_W'($urandom));
         expect_word(src[0]);
         send_word(src.pop_front(), WORD_W, 1'b0, 1'b0);
      end
      send_word(WORD_W'($urandom), 3, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 check_all_zero("midreset");
      check("queues_before_reset", 32'(word_q.size() + rtc_q.size() + frame_q.size()), 32'(0));
      m_ptr = 0;
      m_bank = 1'b0;
      m_rtc = '0;
      link.rx_en = 1'b0; link.rx_bit_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      src = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_frame(RTC_W'($urandom), 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (5) tick();
      check("rtc_q_drained", 32'(rtc_q.size()), 32'(0));
      check("word_q_drained", 32'(word_q.size()), 32'(0));
      check("frame_q_drained", 32'(frame_q.size()), 32'(0));
      check("short_q_drained", 32'(short_q.size()), 32'(0));
      check("busy_idle", 32'(busy), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
